// File: rtl/jericalla_sequencer.sv
// jericalla_sequencer: start/busy/done program engine for the ROM->ALU->RAM datapath; `SINGLE_STEP_EN adds step_req and a PAUSE state
module jericalla_sequencer #(
  parameter int PC_W       = 8,
  parameter int START_ADDR = 0,
  parameter int MAX_STEPS  = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
`ifdef SINGLE_STEP_EN
  input  logic            step_req,
`endif
  output logic            busy,
  output logic            done,
  output logic            timeout,
  output logic [PC_W-1:0] pm_addr,
  input  logic [16:0]     pm_data,
  output logic [16:0]     dp_instr,
  input  logic            dp_zf,
  output logic            zf_flag,
  output logic [PC_W-1:0] pc
);
  localparam int STEP_W = $clog2(MAX_STEPS + 1);
  localparam logic [PC_W-1:0] START = PC_W'(START_ADDR);
  typedef enum logic [2:0] {
    IDLE, FETCH, LOAD, EXEC, DONE
`ifdef SINGLE_STEP_EN
    , PAUSE
`endif
  } state_t;
  state_t            r_state, w_next;
  logic [PC_W-1:0]   r_pc;
  logic [16:0]       r_ir;
  logic [STEP_W-1:0] r_step, w_step_inc;
  logic              r_timeout, r_zf, w_exec, w_halt, w_jz, w_to;
  logic [7:0]        w_tgt;
  assign busy    = r_state != IDLE;
  assign done    = r_state == DONE;
  assign timeout = r_timeout;
  assign zf_flag = r_zf;
  assign pc      = r_pc;
  assign pm_addr = r_pc;
  // decode the held instruction, pick the next state and gate the datapath word
  always_comb begin
    w_exec     = r_state == EXEC;
    w_halt     = r_ir[12:9] == 4'hF;
    w_jz       = r_ir[12:9] == 4'hE;
    w_step_inc = r_step + STEP_W'(1);
    w_to       = !w_halt && w_step_inc == STEP_W'(MAX_STEPS);
    w_tgt      = r_ir[8:1];
    dp_instr   = (w_exec && !w_halt && !w_jz) ? r_ir : '0;
    w_next     = r_state;
    case (r_state)
      IDLE:    w_next = start ? FETCH : IDLE;
      FETCH:   w_next = LOAD;
      LOAD:    w_next = EXEC;
`ifdef SINGLE_STEP_EN
      EXEC:    w_next = (w_halt || w_to) ? DONE : PAUSE;
      PAUSE:   w_next = step_req ? FETCH : PAUSE;
`else
      EXEC:    w_next = (w_halt || w_to) ? DONE : FETCH;
`endif
      default: w_next = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk) r_state <= rst ? IDLE : w_next;
  // program counter, instruction register, step count and flags
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc      <= START;
      r_ir      <= '0;
      r_step    <= '0;
      r_timeout <= 1'b0;
      r_zf      <= 1'b0;
    end else if (r_state == IDLE && start) begin
      r_pc      <= START;
      r_step    <= '0;
      r_timeout <= 1'b0;
      r_zf      <= 1'b0;
    end else if (r_state == LOAD) begin
      r_ir <= pm_data;
    end else if (w_exec) begin
      r_step    <= w_step_inc;
      r_timeout <= w_to;
      if (!w_halt) r_pc <= (w_jz && r_zf) ? w_tgt[PC_W-1:0] : r_pc + 1'b1;
      if (!w_halt && !w_jz) r_zf <= dp_zf;
    end
  end
endmodule

// File: tb/tb_jericalla_sequencer.sv
// tb_jericalla_sequencer: randomized and directed programs checked against an instruction-level model
module tb_jericalla_sequencer;
  logic clk = 0, rst = 1, start0 = 0, start1 = 0;
  logic busy0, done0, to0, zf0, busy1, done1, to1, zf1;
  logic [7:0] pm_addr0, pc0;
  logic [1:0] pm_addr1, pc1;
  logic [16:0] pm_data0, pm_data1, dp0, dp1;
  logic [16:0] mem [2][256];
  int tests = 0, fails = 0;
  int m_n, m_pc;
  logic m_zf, m_to;
  int m_c[$], o_c[$];
  logic [16:0] m_w[$], o_w[$];

  always #5 clk = ~clk;

  function automatic logic fz(logic [16:0] w);
    return w[0] && (w[4:1] == w[8:5]);
  endfunction
  function automatic logic [16:0] mk(int r, int op, int d2, int d1, int en);
    return {4'(r), 4'(op), 4'(d2), 4'(d1), 1'(en)};
  endfunction

  jericalla_sequencer u0 (.clk(clk), .rst(rst), .start(start0), .busy(busy0), .done(done0),
    .timeout(to0), .pm_addr(pm_addr0), .pm_data(pm_data0), .dp_instr(dp0), .dp_zf(fz(dp0)),
    .zf_flag(zf0), .pc(pc0));
  jericalla_sequencer #(.PC_W(2), .START_ADDR(3), .MAX_STEPS(4)) u1 (.clk(clk), .rst(rst),
    .start(start1), .busy(busy1), .done(done1), .timeout(to1), .pm_addr(pm_addr1),
    .pm_data(pm_data1), .dp_instr(dp1), .dp_zf(fz(dp1)), .zf_flag(zf1), .pc(pc1));

  always_ff @(posedge clk) begin
    pm_data0 <= mem[0][pm_addr0];
    pm_data1 <= mem[1][pm_addr1];
  end

  function automatic logic [16:0] f_dp(int s); return s ? dp1 : dp0; endfunction
  function automatic logic f_busy(int s); return s ? busy1 : busy0; endfunction
  function automatic logic f_done(int s); return s ? done1 : done0; endfunction
  function automatic logic f_to(int s); return s ? to1 : to0; endfunction
  function automatic logic f_zf(int s); return s ? zf1 : zf0; endfunction
  function automatic int f_pc(int s); return s ? int'(pc1) : int'(pc0); endfunction
  function automatic int f_pa(int s); return s ? int'(pm_addr1) : int'(pm_addr0); endfunction

  task automatic set_start(int s, logic v);
    if (s != 0) start1 = v; else start0 = v;
  endtask

  // instruction-level reference: k-th executed instruction is issued in cycle 3k after start
  task automatic model(int s);
    int p, mask, maxs;
    logic [16:0] w;
    logic z;
    mask = s ? 3 : 255; maxs = s ? 4 : 255; p = s ? 3 : 0;
    m_c.delete(); m_w.delete(); m_n = 0; m_to = 0; z = 0;
    while (1) begin
      w = mem[s][p]; m_n++;
      if (w[12:9] == 4'hF) break;
      if (w[12:9] == 4'hE) p = z ? (int'(w[8:1]) & mask) : ((p + 1) & mask);
      else begin
        if (w != 0) begin m_c.push_back(3 * m_n); m_w.push_back(w); end
        z = fz(w); p = (p + 1) & mask;
      end
      if (m_n == maxs) begin m_to = 1; break; end
    end
    m_pc = p; m_zf = z;
  endtask

  task automatic run(int s, string nm);
    int cyc, bad;
    logic [16:0] prev;
    model(s);
    o_c.delete(); o_w.delete(); bad = 0; prev = 0; cyc = 0;
    @(negedge clk); set_start(s, 1);
    do begin
      @(negedge clk); cyc++;
      set_start(s, 1'($urandom_range(0, 1)));
      if (!f_busy(s) || f_pa(s) != f_pc(s)) bad++;
      if (f_dp(s) != 0) begin
        o_c.push_back(cyc); o_w.push_back(f_dp(s));
        if (prev != 0) bad++;
      end
      prev = f_dp(s);
      if (cyc == 1) begin
        tests++;
        if (f_to(s) !== 1'b0) begin fails++; $display("FAIL %s timeout_cleared got %b want 0", nm, f_to(s)); end
      end
    end while (!f_done(s) && cyc < 2000);
    set_start(s, 0);
    tests++;
    if (cyc != 3 * m_n + 1) begin fails++; $display("FAIL %s done_cycle got %0d want %0d", nm, cyc, 3 * m_n + 1); end
    tests++;
    if (f_to(s) !== m_to) begin fails++; $display("FAIL %s timeout got %b want %b", nm, f_to(s), m_to); end
    tests++;
    if (f_zf(s) !== m_zf) begin fails++; $display("FAIL %s zf_flag got %b want %b", nm, f_zf(s), m_zf); end
    tests++;
    if (f_pc(s) != m_pc) begin fails++; $display("FAIL %s final_pc got %0d want %0d", nm, f_pc(s), m_pc); end
    tests++;
    if (bad != 0) begin fails++; $display("FAIL %s busy_pmaddr_en got %0d bad cycles want 0", nm, bad); end
    tests++;
    if (o_w.size() != m_w.size()) begin
      fails++; $display("FAIL %s issue_count got %0d want %0d", nm, o_w.size(), m_w.size());
    end else foreach (m_w[i]) begin
      tests++;
      if (o_w[i] !== m_w[i] || o_c[i] != m_c[i]) begin
        fails++; $display("FAIL %s issue%0d got %h@%0d want %h@%0d", nm, i, o_w[i], o_c[i], m_w[i], m_c[i]);
      end
    end
    @(negedge clk);
    tests++;
    if (f_busy(s) !== 1'b0 || f_done(s) !== 1'b0 || f_dp(s) !== '0) begin
      fails++; $display("FAIL %s after_done busy=%b done=%b dp=%h want 0 0 0", nm, f_busy(s), f_done(s), f_dp(s));
    end
  endtask

  task automatic fill(int s, int n);
    for (int a = 0; a < n; a++) begin
      int r;
      r = $urandom_range(0, 9);
      mem[s][a] = r == 0 ? mk($urandom, 15, $urandom, $urandom, $urandom) :
                  r == 1 ? mk($urandom, 14, $urandom, $urandom, $urandom) :
                  mk($urandom, $urandom_range(0, 13), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3) != 0);
    end
  endtask

  task automatic test_reset;
    rst = 1;
    repeat (2) @(negedge clk);
    tests++;
    if ({busy0, done0, to0, zf0, dp0, pc0, pm_addr0} !== '0) begin
      fails++; $display("FAIL reset_u0 got b%b d%b t%b z%b dp%h pc%h pa%h want all 0", busy0, done0, to0, zf0, dp0, pc0, pm_addr0);
    end
    tests++;
    if ({busy1, done1, to1, zf1, dp1} !== '0 || pc1 !== 2'd3 || pm_addr1 !== 2'd3) begin
      fails++; $display("FAIL reset_u1 got b%b dp%h pc%0d pa%0d want 0 0 3 3", busy1, dp1, pc1, pm_addr1);
    end
    rst = 0;
  endtask

  task automatic test_single_alu;
    fill(0, 256);
    mem[0][0] = mk(3, 2, 1, 0, 1);
    mem[0][1] = mk(0, 15, 0, 0, 0);
    run(0, "single_alu");
  endtask

  task automatic test_jz;
    fill(0, 256);
    mem[0][0] = mk(1, 3, 2, 2, 1);
    mem[0][1] = mk(0, 14, 0, 5, 0);
    for (int a = 2; a < 5; a++) mem[0][a] = mk($urandom, $urandom_range(0, 13), $urandom, $urandom, 1);
    mem[0][5] = mk(0, 15, 0, 0, 0);
    run(0, "jz_taken");
    mem[0][0] = mk(1, 3, 2, 7, 1);
    mem[0][2] = mk(0, 15, 0, 0, 0);
    run(0, "jz_fall");
  endtask

  task automatic test_self_loop;
    mem[0][0] = mk(1, 1, 4, 4, 1);
    mem[0][1] = mk(0, 14, 0, 1, 0);
    run(0, "self_loop");
    mem[0][1] = mk(0, 15, 0, 0, 0);
    run(0, "after_timeout");
  endtask

  task automatic test_max_steps;
    for (int a = 0; a < 4; a++) mem[1][a] = mk($urandom, $urandom_range(0, 13), $urandom, $urandom, 1);
    run(1, "max_steps");
    mem[1][1] = mk(0, 15, 0, 0, 0);
    run(1, "max_steps_clear");
  endtask

  task automatic test_wrap;
    mem[1][3] = mk(2, 4, 1, 3, 1);
    mem[1][0] = mk(0, 15, 0, 0, 0);
    run(1, "wrap");
  endtask

  task automatic test_random;
    for (int k = 0; k < 20; k++) begin fill(0, 256); run(0, "rand_u0"); end
    for (int k = 0; k < 12; k++) begin fill(1, 4); run(1, "rand_u1"); end
  endtask

  task automatic test_reset_mid;
    int cyc;
    for (int a = 0; a < 8; a++) mem[0][a] = mk($urandom, $urandom_range(0, 13), 1, 1, 1);
    @(negedge clk); start0 = 1;
    cyc = 0;
    do begin @(negedge clk); start0 = 1; cyc++; end while (dp0 == 0 && cyc < 20);
    tests++;
    if (dp0 == 0) begin fails++; $display("FAIL reset_mid no_issue got 0 want nonzero"); end
    rst = 1; start0 = 0;
    @(negedge clk);
    tests++;
    if (dp0 !== '0 || busy0 !== 1'b0 || pc0 !== 8'd0 || done0 !== 1'b0 || zf0 !== 1'b0) begin
      fails++; $display("FAIL reset_mid got dp%h b%b pc%h d%b z%b want 0", dp0, busy0, pc0, done0, zf0);
    end
    rst = 0;
    repeat (2) @(negedge clk);
    tests++;
    if (busy0 !== 1'b0 || dp0 !== '0) begin fails++; $display("FAIL reset_mid_idle got b%b dp%h want 0 0", busy0, dp0); end
  endtask

  initial begin
    foreach (mem[s, a]) mem[s][a] = '0;
    test_reset;
    test_single_alu;
    test_jz;
    test_self_loop;
    test_max_steps;
    test_wrap;
    test_random;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
